// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate L1 D-cache; ports: clk_i/rst_i, p1_* CPU MEM-stage side, mem_* off-chip line side
module dcache_ctrl #(
  parameter int IDX_W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int TAG_W = 27 - IDX_W;
  localparam int NUM_LINES = 2 ** IDX_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
  state_t state, state_nx;
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [NUM_LINES];
  logic [255:0] lines [NUM_LINES];
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [7:0] bit_ofs;
  logic req, hit, miss, fill, store_hit, unused_ok;
  assign tag = p1_addr_i[31:5+IDX_W];
  assign idx = p1_addr_i[4+IDX_W:5];
  assign bit_ofs = {p1_addr_i[4:2], 5'b0};
  assign unused_ok = &{1'b0, p1_addr_i[1:0]};
  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign hit = req & valid[idx] & (tags[idx] == tag);
  assign miss = rst_i & req & ~hit;
  assign fill = (state == ALLOCATE) & mem_ack_i;
  assign store_hit = (state == IDLE) & hit & p1_MemWrite_i;
  always_comb begin
    state_nx = state;
    p1_stall_o = 1'b1;
    mem_enable_o = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    p1_data_o = (state == IDLE && hit) ? lines[idx][bit_ofs +: 32] : 32'd0;
    case (state)
      IDLE: begin
        p1_stall_o = miss;
        state_nx = !miss ? IDLE : (valid[idx] & dirty[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o = {tags[idx], idx, 5'b0};
        mem_data_o = lines[idx];
        state_nx = mem_ack_i ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o = {tag, idx, 5'b0};
        state_nx = mem_ack_i ? REFILL : ALLOCATE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nx;
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (store_hit) dirty[idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (fill) begin
      lines[idx] <= mem_data_i;
      tags[idx] <= tag;
    end else if (store_hit) lines[idx][bit_ofs +: 32] <= p1_data_i;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboarded random and directed bench for dcache_ctrl against a flat-memory reference
module tb_dcache_ctrl;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0;
  logic [31:0] p1_addr_i = '0, p1_data_i = '0, p1_data_o, mem_addr_o;
  logic p1_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [255:0] mem_data_o, mem_data_i;
  always #5 clk_i = ~clk_i;
  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );
  typedef struct { bit load; logic [31:0] data; int stall; } exp_t;
  typedef struct { bit w; logic [31:0] a; logic [255:0] d; int lat; } req_t;
  exp_t sb[$];
  req_t rq[$];
  logic [255:0] mem_line [512];
  logic [31:0] ref_word [4096];
  bit mv [32], md [32];
  logic [21:0] mt [32];
  int errors = 0, checks = 0;
  task automatic chk(string n, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask
  function automatic logic [255:0] line_of(int la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word[la*8 + w];
    return l;
  endfunction
  task automatic access(bit w, bit both, logic [31:0] a, logic [31:0] d, int lwb, int lal);
    int idx, st, n;
    logic [21:0] t;
    idx = int'(a[9:5]);
    t = a[31:10];
    st = 0;
    n = 0;
    if (!(mv[idx] && mt[idx] == t)) begin
      st = 2 + lal;
      if (md[idx]) begin
        rq.push_back('{1'b1, {mt[idx], a[9:5], 5'b0}, line_of(int'({mt[idx], a[9:5]})), lwb});
        st += lwb;
      end
      rq.push_back('{1'b0, {t, a[9:5], 5'b0}, 256'd0, lal});
      mv[idx] = 1'b1;
      mt[idx] = t;
      md[idx] = 1'b0;
    end
    if (w) begin
      ref_word[a[13:2]] = d;
      md[idx] = 1'b1;
    end
    sb.push_back('{!w, ref_word[a[13:2]], st});
    p1_MemRead_i = !w || both;
    p1_MemWrite_i = w;
    p1_addr_i = a;
    p1_data_i = d;
    do begin
      @(negedge clk_i);
      n++;
    end while (p1_stall_o && n < 1000);
    if (n >= 1000) begin
      chk("access_timeout", p1_stall_o, 0);
      finish_run();
    end
    @(posedge clk_i);
    #1;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    for (int i = 0; i < 4096; i++) ref_word[i] = mem_line[i/8][(i%8)*32 +: 32];
  endtask
  initial begin : monitor
    int sc;
    exp_t e;
    sc = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) sc = 0;
      else if (p1_MemRead_i || p1_MemWrite_i) begin
        if (p1_stall_o) sc++;
        else begin
          if (sb.size() == 0) chk("sb_underflow", p1_MemRead_i | p1_MemWrite_i, 0);
          else begin
            e = sb.pop_front();
            if (e.load) chk("load_data", p1_data_o, e.data);
            chk("stall_cycles", sc, e.stall);
          end
          sc = 0;
        end
      end
    end
  end
  initial begin : responder
    int cnt;
    req_t cur;
    bit stable;
    logic [288:0] snap;
    cnt = 0;
    stable = 1'b1;
    snap = '0;
    cur = '{1'b0, 32'd0, 256'd0, 1};
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i or negedge rst_i);
      mem_ack_i = 1'b0;
      if (!rst_i) cnt = 0;
      else if (mem_enable_o) begin
        if (cnt == 0) begin
          if (rq.size() == 0) begin
            chk("mem_unexpected", mem_enable_o, 0);
            cur = '{mem_write_o, mem_addr_o, mem_data_o, 1};
          end else begin
            cur = rq.pop_front();
            chk("mem_write", mem_write_o, cur.w);
            chk("mem_addr", mem_addr_o, cur.a);
            if (cur.w) chk("wb_data", mem_data_o, cur.d);
          end
          snap = {mem_write_o, mem_addr_o, mem_data_o};
          stable = 1'b1;
        end else if ({mem_write_o, mem_addr_o, mem_data_o} !== snap) stable = 1'b0;
        cnt++;
        if (cnt >= cur.lat) begin
          chk("mem_stable", stable, 1);
          if (mem_write_o) mem_line[mem_addr_o[13:5]] = mem_data_o;
          else mem_data_i = mem_line[mem_addr_o[13:5]];
          mem_ack_i = 1'b1;
          cnt = 0;
        end
      end
    end
  end
  initial begin : driver
    int n;
    for (int i = 0; i < 512; i++)
      for (int w = 0; w < 8; w++) mem_line[i][w*32 +: 32] = $urandom;
    model_reset();
    @(negedge clk_i);
    chk("rst_stall", p1_stall_o, 0);
    chk("rst_data", p1_data_o, 0);
    chk("rst_enable", mem_enable_o, 0);
    chk("rst_write", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_mdata", mem_data_o, 0);
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    access(0, 0, 32'h4, 0, 1, 10);
    access(1, 0, 32'h8, 32'hDEADBEEF, 1, 1);
    access(0, 0, 32'h8, 0, 1, 1);
    access(0, 0, 32'h400, 0, 3, 2);
    access(1, 0, 32'h824, 32'h12345678, 1, 4);
    for (int w = 0; w < 8; w++) access(0, 0, 32'h820 + 32'(w*4), 0, 1, 1);
    access(0, 0, 32'h1040, 0, 1, 1);
    access(0, 0, 32'h2060, 0, 1, 25);
    access(1, 0, 32'h2064, 32'hCAFEF00D, 1, 1);
    access(0, 0, 32'h3064, 0, 1, 25);
    access(1, 1, 32'h2468, 32'h0BADC0DE, 1, 1);
    access(0, 0, 32'h0468, 0, 25, 1);
    access(0, 0, 32'h2468, 0, 1, 1);
    rq.push_back('{1'b0, 32'h1000, 256'd0, 30});
    p1_MemRead_i = 1'b1;
    p1_addr_i = 32'h1000;
    n = 0;
    while (!(mem_enable_o && !mem_write_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("reach_allocate", mem_enable_o, 1);
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_enable", mem_enable_o, 0);
    chk("arst_stall", p1_stall_o, 0);
    chk("arst_addr", mem_addr_o, 0);
    p1_MemRead_i = 1'b0;
    repeat (2) @(negedge clk_i);
    sb.delete();
    rq.delete();
    model_reset();
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    access(0, 0, 32'h4, 0, 1, 3);
    access(0, 0, 32'h8, 0, 1, 1);
    for (int k = 0; k < 250; k++) begin
      bit w;
      w = ($urandom_range(0, 9) < 4);
      access(w, w && $urandom_range(0, 3) == 0,
             {18'd0, 4'($urandom_range(0, 15)), 5'($urandom), 3'($urandom), 2'b00},
             $urandom, $urandom_range(1, 6), $urandom_range(1, 6));
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    repeat (3) @(negedge clk_i);
    chk("sb_drain", sb.size(), 0);
    chk("rq_drain", rq.size(), 0);
    finish_run();
  end
endmodule
